// File: rtl/lcd_pkg.sv
// Shared constants and feeder state encoding for the LCD text feeder.
package lcd_pkg;

  localparam logic [7:0] LCD_SPACE = 8'h20;
  localparam int         LCD_COLS  = 16;
  localparam int         LCD_LINES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LCD_RST,
    ST_REQ,
    ST_STREAM,
    ST_DONE
  } feeder_state_t;

  function automatic logic is_busy(input feeder_state_t s);
    return (s == ST_LCD_RST) || (s == ST_REQ) || (s == ST_STREAM);
  endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Multi-flop synchroniser for one slow driver signal, with a rising-edge strobe
// valid for exactly one clk after the synchronised level goes high.
module lcd_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // NOTE: every flop uses <= so the chain shifts one stage per clk; blocking
  // assignments here would collapse the stages into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;

endmodule

// File: rtl/lcd_text_feeder.sv
// Holds the 2x16 text buffer, starts the LCD driver and presents buf[ptr] on db
// while the driver walks both lines; ptr follows the driver's rs-high en_out edges.
module lcd_text_feeder
  import lcd_pkg::*;
#(
  parameter  int CHARS_PER_LINE = LCD_COLS,
  parameter  int LINES          = LCD_LINES,
  parameter  int RST_CYCLES     = 4,
  parameter  int SYNC_STAGES    = 2,
  localparam int DEPTH          = CHARS_PER_LINE * LINES,
  localparam int ADDR_W         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              wr_err,
  output logic              lcd_rst,
  output logic              init,
  output logic [7:0]        db,
  input  logic              init_done,
  input  logic              rs,
  input  logic              en_out
);

  localparam int                PTR_W   = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_END = PTR_W'(DEPTH);
  localparam int                CNT_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(RST_CYCLES - 1);

  feeder_state_t    state;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] rst_cnt;
  logic [7:0]       text_mem [DEPTH];

  logic en_sync, en_rise, rs_sync, init_done_sync;
  logic unused_rs_rise, unused_init_done_rise;
  logic wr_in_range, wr_accept;

  lcd_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
    .clk  (clk),
    .rst  (rst),
    .d    (en_out),
    .q    (en_sync),
    .rise (en_rise)
  );

  lcd_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rs (
    .clk  (clk),
    .rst  (rst),
    .d    (rs),
    .q    (rs_sync),
    .rise (unused_rs_rise)
  );

  lcd_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_init_done (
    .clk  (clk),
    .rst  (rst),
    .d    (init_done),
    .q    (init_done_sync),
    .rise (unused_init_done_rise)
  );

  // A power-of-two buffer is fully covered by wr_addr, so no range check exists.
  if (DEPTH == (1 << ADDR_W)) begin : g_addr_full
    assign wr_in_range = 1'b1;
  end else begin : g_addr_part
    assign wr_in_range = (PTR_W'(wr_addr) < PTR_END);
  end

  assign wr_accept = wr_en && wr_in_range && !is_busy(state);

  // NOTE: the buffer is a reset flop array rather than a RAM because a reset
  // must leave the screen text blank (all spaces) before any host write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) text_mem[i] <= LCD_SPACE;
    end else if (wr_accept) begin
      text_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db <= LCD_SPACE;
    end else if (ptr < PTR_END) begin
      db <= text_mem[ptr[ADDR_W-1:0]];
    end else begin
      db <= LCD_SPACE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      rst_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_err  <= 1'b0;
      lcd_rst <= 1'b0;
      init    <= 1'b0;
    end else begin
      wr_err <= wr_en && wr_in_range && is_busy(state);

      // One step per character strobe; saturates after the second line.
      if (en_rise && rs_sync && (ptr < PTR_END)) begin
        ptr <= ptr + PTR_W'(1);
      end

      unique case (state)
        ST_IDLE: begin
          // IDLE is only reached from reset, so the driver is already fresh.
          if (start) begin
            state <= ST_REQ;
            ptr   <= '0;
            busy  <= 1'b1;
            init  <= 1'b1;
          end
        end
        ST_LCD_RST: begin
          if (rst_cnt == CNT_END) begin
            state   <= ST_REQ;
            lcd_rst <= 1'b0;
            init    <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + CNT_W'(1);
          end
        end
        ST_REQ: begin
          if (init_done_sync) begin
            state <= ST_STREAM;
            init  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if ((ptr == PTR_END) && !init_done_sync) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state   <= ST_LCD_RST;
            ptr     <= '0;
            rst_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            lcd_rst <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
